tvip_axi_burst_beat_generator: RTL and testbench
================================================

Name: tvip_axi_burst_beat_generator

Overview:
- Downstream consumer of the AXI address-channel types (address, burst length, burst size, burst type).
- Takes one accepted AW/AR request and expands it into per-beat transfer descriptors: beat address, byte-lane strobe, beat index and last flag.
- Sits between the request queue and the write-data/read-data beat handling in the slave-side VIP and RTL harness.

Parameters:
- ADDRESS_WIDTH, 64, width of request and beat addresses; must be ≤ TVIP_AXI_MAX_ADDRESS_WIDTH.
- DATA_WIDTH, 32, data bus width in bits; power of two, 8..1024.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous reset, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready; high only in IDLE.
- req_address  in  ADDRESS_WIDTH  start address.
- req_burst_length  in  8  encoded AxLEN (beats-1), tvip_axi_burst_length.
- req_burst_size  in  3  tvip_axi_burst_size.
- req_burst_type  in  2  tvip_axi_burst_type.
- beat_valid  out  1  beat descriptor valid.
- beat_ready  in  1  consumer accepts beat.
- beat_address  out  ADDRESS_WIDTH  address of current beat.
- beat_strobe  out  DATA_WIDTH/8  active byte lanes of current beat.
- beat_index  out  8  beat number, 0-based.
- beat_last  out  1  final beat of burst.
- req_error  out  1  sticky-per-burst illegal-request flag, valid with beat_valid.

Behaviour:
- Reset (async assert): state=IDLE; req_ready=1; beat_valid=0, beat_address=0, beat_strobe=0, beat_index=0, beat_last=0, req_error=0. Reset mid-burst abandons the burst; no further beats.
- FSM states:
  - IDLE: accept on req_valid&&req_ready, latch request, go to BURST.
  - BURST: beat_valid=1; on beat_valid&&beat_ready, if beat_last go to IDLE, else advance.
- Latency: first beat_valid the cycle after acceptance. No request accepted in the cycle the last beat retires; req_ready rises the following cycle.
- Outputs hold stable while beat_valid&&!beat_ready.
- Derived quantities: bytes = 1<<size; len = burst_length+1; aligned = start & ~(bytes-1).
- FIXED: every beat address = start; strobe identical each beat.
- INCR: beat0 address = start (unaligned allowed); beat n = aligned + n*bytes. Address arithmetic wraps modulo 2^ADDRESS_WIDTH.
- WRAP: span = bytes*len; lower = start & ~(span-1). Next = addr+bytes; if next == lower+span, next = lower.
- Strobe: lanes from (addr mod DATA_WIDTH/8) up to ((aligned_beat mod DATA_WIDTH/8) + bytes - 1). Only beat0 of INCR/FIXED can be partial at the low end.
- beat_last = (beat_index == burst_length).
- req_error=1 for the whole burst if any of:
  - bytes > DATA_WIDTH/8: size clamped to bus width.
  - burst type 'b11: treated as INCR.
  - WRAP with len not in {2,4,8,16}: treated as INCR.
  - WRAP with unaligned start: start aligned down.
- Burst still runs to completion with len beats in all error cases.

Optional Feature:
- Macro: TVIP_AXI_BURST_BEAT_4KB_CHECK_EN.
- Defined: an INCR burst whose last byte lies in a different 4 KB page than start also sets req_error; beats are still generated unchanged.
- Undefined: no 4 KB check; req_error covers only the cases listed above.

Decomposition:
- Shared package (tvip_axi_types_pkg) supplies:
  - types tvip_axi_burst_length, tvip_axi_burst_size, tvip_axi_burst_type;
  - unpack_burst_length and unpack_burst_size;
  - a new constant TVIP_AXI_4KB_BOUNDARY = 4096.
- One sub-module: tvip_axi_strobe_calc, a purely combinational helper: (address, size) -> strobe.

Test Plan:
- INCR, addr 0x1002, len=3 (4 beats), size 4B, DATA_WIDTH=32 -> addrs 0x1002,0x1004,0x1008,0x100C; strobes 0xC,0xF,0xF,0xF; last on index 3; first beat_valid 1 cycle after accept.
- WRAP, addr 0x1038, len=3, size 4B -> addrs 0x1038,0x103C,0x1030,0x1034; req_error=0.
- FIXED, addr 0x20, len=2, size 2B -> 3 beats at 0x20, strobe 0x3 each; beat_ready held low 5 cycles mid-burst -> outputs stable, index unchanged.
- WRAP len=2 (3 beats) -> req_error=1, INCR addresses; size 8B on 32-bit bus -> req_error=1, strobe 0xF.
- Reset asserted during beat 2 of 8 -> beat_valid=0 same cycle, req_ready=1 after release; next request starts at index 0.
- With TVIP_AXI_BURST_BEAT_4KB_CHECK_EN: INCR addr 0xFF8, len=3, size 4B -> req_error=1; without the macro -> req_error=0.

Source files
------------

// File: rtl/tvip_axi_types_pkg.sv
// ---------------------------------------------------------------------------
// tvip_axi_types_pkg
// Shared AXI address-channel types and helpers.
//   - tvip_axi_burst_length : encoded AxLEN (beats - 1)
//   - tvip_axi_burst_size   : encoded AxSIZE (log2 of bytes per beat)
//   - tvip_axi_burst_type   : encoded AxBURST, plus named encodings
//   - unpack_burst_length() : AxLEN -> number of beats (1..256)
//   - unpack_burst_size()   : AxSIZE -> bytes per beat (1..128)
//   - TVIP_AXI_4KB_BOUNDARY : AXI page size that bursts must not cross
// ---------------------------------------------------------------------------
package tvip_axi_types_pkg;

  localparam int TVIP_AXI_MAX_ADDRESS_WIDTH = 64;
  localparam int TVIP_AXI_4KB_BOUNDARY      = 4096;

  typedef logic [7:0] tvip_axi_burst_length;
  typedef logic [2:0] tvip_axi_burst_size;
  typedef logic [1:0] tvip_axi_burst_type;

  localparam tvip_axi_burst_type TVIP_AXI_FIXED_BURST        = 2'b00;
  localparam tvip_axi_burst_type TVIP_AXI_INCREMENTING_BURST = 2'b01;
  localparam tvip_axi_burst_type TVIP_AXI_WRAPPING_BURST     = 2'b10;
  localparam tvip_axi_burst_type TVIP_AXI_RESERVED_BURST     = 2'b11;

  typedef enum logic {
    BEAT_GEN_IDLE  = 1'b0,
    BEAT_GEN_BURST = 1'b1
  } tvip_axi_beat_gen_state_e;

  function automatic logic [8:0] unpack_burst_length(input tvip_axi_burst_length burst_length);
    return {1'b0, burst_length} + 9'd1;
  endfunction

  function automatic logic [7:0] unpack_burst_size(input tvip_axi_burst_size burst_size);
    return 8'd1 << burst_size;
  endfunction

endpackage

// File: rtl/tvip_axi_strobe_calc.sv
// ---------------------------------------------------------------------------
// tvip_axi_strobe_calc
// Combinational byte-lane strobe for one beat.
// Ports:
//   address (in, ADDRESS_WIDTH) : beat address (may be unaligned)
//   size    (in, 3)             : encoded beat size, already clamped to bus
//   strobe  (out, DATA_WIDTH/8) : lanes from the address lane up to the end
//                                 of the size-aligned container
// ---------------------------------------------------------------------------
module tvip_axi_strobe_calc
  import tvip_axi_types_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 64,
  parameter int DATA_WIDTH    = 32
) (
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  tvip_axi_burst_size       size,
  output logic [DATA_WIDTH/8-1:0]  strobe
);

  localparam int BUS_BYTES = DATA_WIDTH / 8;

  int bytes_s;
  int lane_lo_s;
  int lane_hi_s;

  // Lane window: low end is the address lane, high end closes the aligned container.
  always_comb begin
    bytes_s   = int'(unpack_burst_size(size));
    lane_lo_s = int'(address & ADDRESS_WIDTH'(BUS_BYTES - 1));
    lane_hi_s = (lane_lo_s & ~(bytes_s - 1)) + bytes_s - 1;
    for (int i = 0; i < BUS_BYTES; i++) begin
      strobe[i] = (i >= lane_lo_s) && (i <= lane_hi_s);
    end
  end

endmodule

// File: rtl/tvip_axi_burst_beat_generator.sv
// ---------------------------------------------------------------------------
// tvip_axi_burst_beat_generator
// Expands one accepted AW/AR request into per-beat descriptors.
// Ports:
//   aclk, areset (async, active-high)
//   req_valid/req_ready, req_address, req_burst_length, req_burst_size,
//   req_burst_type                  : request handshake (ready only in IDLE)
//   beat_valid/beat_ready, beat_address, beat_strobe, beat_index,
//   beat_last, req_error            : beat descriptor handshake
// Optional build macro: TVIP_AXI_BURST_BEAT_4KB_CHECK_EN -- when defined, an
// INCR burst crossing a 4 KB page also raises req_error (beats unchanged).
// ---------------------------------------------------------------------------
module tvip_axi_burst_beat_generator
  import tvip_axi_types_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 64,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  tvip_axi_burst_length     req_burst_length,
  input  tvip_axi_burst_size       req_burst_size,
  input  tvip_axi_burst_type       req_burst_type,
  output logic                     beat_valid,
  input  logic                     beat_ready,
  output logic [ADDRESS_WIDTH-1:0] beat_address,
  output logic [DATA_WIDTH/8-1:0]  beat_strobe,
  output logic [7:0]               beat_index,
  output logic                     beat_last,
  output logic                     req_error
);

  localparam int                       BUS_SIZE     = $clog2(DATA_WIDTH / 8);
  localparam tvip_axi_burst_size       BUS_SIZE_ENC = tvip_axi_burst_size'(BUS_SIZE);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE     = ADDRESS_WIDTH'(1);
`ifdef TVIP_AXI_BURST_BEAT_4KB_CHECK_EN
  localparam int                       PAGE_BITS    = $clog2(TVIP_AXI_4KB_BOUNDARY);
`endif

  tvip_axi_beat_gen_state_e state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] lower_q, lower_d;
  logic [ADDRESS_WIDTH-1:0] upper_q, upper_d;
  tvip_axi_burst_size       size_q, size_d;
  tvip_axi_burst_type       type_q, type_d;
  tvip_axi_burst_length     len_q, len_d;
  logic [7:0]               index_q, index_d;
  logic                     error_q, error_d;

  logic [ADDRESS_WIDTH-1:0] acc_start;
  logic [ADDRESS_WIDTH-1:0] acc_bytes;
  logic [ADDRESS_WIDTH-1:0] acc_span;
  logic [ADDRESS_WIDTH-1:0] acc_lower;
  logic [8:0]               acc_len;
  tvip_axi_burst_size       acc_size;
  tvip_axi_burst_type       acc_type;
  logic                     acc_error;
`ifdef TVIP_AXI_BURST_BEAT_4KB_CHECK_EN
  logic [ADDRESS_WIDTH-1:0] acc_last_byte;
`endif

  logic [ADDRESS_WIDTH-1:0] step_bytes;
  logic [ADDRESS_WIDTH-1:0] wrap_next;
  logic [ADDRESS_WIDTH-1:0] next_addr;
  logic                     in_burst;
  logic                     last_beat;
  logic [DATA_WIDTH/8-1:0]  calc_strobe;

  // Request legalisation: illegal requests are coerced to something runnable and flagged.
  always_comb begin
    acc_error = 1'b0;
    acc_start = req_address;
    acc_type  = req_burst_type;
    acc_len   = unpack_burst_length(req_burst_length);
    if (req_burst_size > BUS_SIZE_ENC) begin
      acc_size  = BUS_SIZE_ENC;
      acc_error = 1'b1;
    end else begin
      acc_size  = req_burst_size;
    end
    acc_bytes = ADDRESS_WIDTH'(unpack_burst_size(acc_size));
    case (req_burst_type)
      TVIP_AXI_FIXED_BURST, TVIP_AXI_INCREMENTING_BURST: begin
        acc_start = req_address;
      end
      TVIP_AXI_WRAPPING_BURST: begin
        if (!(acc_len inside {9'd2, 9'd4, 9'd8, 9'd16})) begin
          acc_type  = TVIP_AXI_INCREMENTING_BURST;
          acc_error = 1'b1;
        end else if ((req_address & (acc_bytes - ADDR_ONE)) != '0) begin
          acc_start = req_address & ~(acc_bytes - ADDR_ONE);
          acc_error = 1'b1;
        end else begin
          acc_start = req_address;
        end
      end
      default: begin
        acc_type  = TVIP_AXI_INCREMENTING_BURST;
        acc_error = 1'b1;
      end
    endcase
    // Total burst bytes; doubles as the wrap window for legal WRAP bursts.
    acc_span  = acc_bytes * ADDRESS_WIDTH'(acc_len);
    acc_lower = acc_start & ~(acc_span - ADDR_ONE);
`ifdef TVIP_AXI_BURST_BEAT_4KB_CHECK_EN
    acc_last_byte = (acc_start & ~(acc_bytes - ADDR_ONE)) + acc_span - ADDR_ONE;
    if ((acc_type == TVIP_AXI_INCREMENTING_BURST) &&
        (acc_start[ADDRESS_WIDTH-1:PAGE_BITS] != acc_last_byte[ADDRESS_WIDTH-1:PAGE_BITS])) begin
      acc_error = 1'b1;
    end else begin
      acc_error = acc_error;
    end
`endif
  end

  // Address of the beat after the current one.
  always_comb begin
    step_bytes = ADDRESS_WIDTH'(unpack_burst_size(size_q));
    wrap_next  = addr_q + step_bytes;
    case (type_q)
      TVIP_AXI_FIXED_BURST:    next_addr = addr_q;
      TVIP_AXI_WRAPPING_BURST: next_addr = (wrap_next == upper_q) ? lower_q : wrap_next;
      default:                 next_addr = (addr_q & ~(step_bytes - ADDR_ONE)) + step_bytes;
    endcase
  end

  assign in_burst  = (state_q == BEAT_GEN_BURST);
  assign last_beat = (index_q == len_q);

  // Next-state logic for the request/beat FSM.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lower_d = lower_q;
    upper_d = upper_q;
    size_d  = size_q;
    type_d  = type_q;
    len_d   = len_q;
    index_d = index_q;
    error_d = error_q;
    case (state_q)
      BEAT_GEN_IDLE: begin
        if (req_valid) begin
          state_d = BEAT_GEN_BURST;
          addr_d  = acc_start;
          lower_d = acc_lower;
          upper_d = acc_lower + acc_span;
          size_d  = acc_size;
          type_d  = acc_type;
          len_d   = req_burst_length;
          index_d = 8'd0;
          error_d = acc_error;
        end else begin
          state_d = BEAT_GEN_IDLE;
        end
      end
      BEAT_GEN_BURST: begin
        if (beat_ready && last_beat) begin
          state_d = BEAT_GEN_IDLE;
        end else if (beat_ready) begin
          index_d = index_q + 8'd1;
          addr_d  = next_addr;
        end else begin
          state_d = BEAT_GEN_BURST;
        end
      end
      default: begin
        state_d = BEAT_GEN_IDLE;
      end
    endcase
  end

  // State and burst-context registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= BEAT_GEN_IDLE;
      addr_q  <= '0;
      lower_q <= '0;
      upper_q <= '0;
      size_q  <= 3'd0;
      type_q  <= TVIP_AXI_FIXED_BURST;
      len_q   <= 8'd0;
      index_q <= 8'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lower_q <= lower_d;
      upper_q <= upper_d;
      size_q  <= size_d;
      type_q  <= type_d;
      len_q   <= len_d;
      index_q <= index_d;
      error_q <= error_d;
    end
  end

  tvip_axi_strobe_calc #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_strobe_calc (
    .address (addr_q),
    .size    (size_q),
    .strobe  (calc_strobe)
  );

  // Per-beat qualifiers are masked outside a burst so idle/reset outputs read as zero.
  assign req_ready    = (state_q == BEAT_GEN_IDLE);
  assign beat_valid   = in_burst;
  assign beat_address = addr_q;
  assign beat_index   = index_q;
  assign beat_strobe  = in_burst ? calc_strobe : '0;
  assign beat_last    = in_burst & last_beat;
  assign req_error    = in_burst & error_q;

endmodule

// File: tb/tb_tvip_axi_burst_beat_generator.sv
module tb_tvip_axi_burst_beat_generator;
  import tvip_axi_types_pkg::*;

`ifdef TVIP_AXI_BURST_BEAT_4KB_CHECK_EN
  localparam logic PG_ERR = 1'b1;
`else
  localparam logic PG_ERR = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        areset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_address;
  logic [7:0]  req_burst_length;
  logic [2:0]  req_burst_size;
  logic [1:0]  req_burst_type;
  logic        beat_valid;
  logic        beat_ready;
  logic [63:0] beat_address;
  logic [3:0]  beat_strobe;
  logic [7:0]  beat_index;
  logic        beat_last;
  logic        req_error;

  tvip_axi_burst_beat_generator #(.ADDRESS_WIDTH(64), .DATA_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_address(req_address),
    .req_burst_length(req_burst_length), .req_burst_size(req_burst_size),
    .req_burst_type(req_burst_type),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_address(beat_address),
    .beat_strobe(beat_strobe), .beat_index(beat_index), .beat_last(beat_last),
    .req_error(req_error)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [63:0] obs_addr[$];
  logic [3:0]  obs_strb[$];
  logic        obs_err[$];
  logic [63:0] exp_addr[$];
  logic [3:0]  exp_strb[$];
  logic        exp_err;

  typedef struct {
    logic [63:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       btype;
    logic             err;
    logic [3:0][63:0] a;
    logic [3:0][3:0]  st;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] bt, input logic err,
                              input logic [63:0] a0, input logic [63:0] a1, input logic [63:0] a2,
                              input logic [63:0] a3, input logic [3:0] s0, input logic [3:0] s1,
                              input logic [3:0] s2, input logic [3:0] s3);
    vec_t v;
    v.addr = addr; v.len = len; v.size = size; v.btype = bt; v.err = err;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    v.st[0] = s0; v.st[1] = s1; v.st[2] = s2; v.st[3] = s3;
    return v;
  endfunction

  // Reference model: beat list straight from the burst rules, using plain 64-bit arithmetic.
  function automatic void model(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s,
                                input logic [1:0] t);
    longint unsigned bytes, start, span, lower, ad;
    int sz, typ, n, lo, hi;
    logic [3:0] m;
    exp_addr.delete();
    exp_strb.delete();
    exp_err = 1'b0;
    sz = int'(s);
    if (sz > 2) begin sz = 2; exp_err = 1'b1; end
    bytes = 64'd1 << sz;
    n = int'(l) + 1;
    typ = int'(t);
    start = a;
    if (typ == 3) begin typ = 1; exp_err = 1'b1; end
    if (typ == 2 && !(n == 2 || n == 4 || n == 8 || n == 16)) begin typ = 1; exp_err = 1'b1; end
    if (typ == 2 && (start % bytes) != 0) begin start = start - (start % bytes); exp_err = 1'b1; end
`ifdef TVIP_AXI_BURST_BEAT_4KB_CHECK_EN
    begin
      longint unsigned last_b;
      last_b = start - (start % bytes) + longint'(n) * bytes - 1;
      if (typ == 1 && (start / 4096) != (last_b / 4096)) exp_err = 1'b1;
    end
`endif
    span = bytes * longint'(n);
    lower = start - (start % span);
    for (int i = 0; i < n; i++) begin
      if (typ == 0) ad = start;
      else if (typ == 1) ad = (i == 0) ? start : start - (start % bytes) + longint'(i) * bytes;
      else ad = lower + ((start - lower) + longint'(i) * bytes) % span;
      lo = int'(ad % 4);
      hi = int'((ad - (ad % bytes)) % 4) + int'(bytes) - 1;
      m = 4'h0;
      for (int b = 0; b < 4; b++) if (b >= lo && b <= hi) m[b] = 1'b1;
      exp_addr.push_back(ad);
      exp_strb.push_back(m);
    end
  endfunction

  // Issue one request and collect its beats, checking handshake behaviour along the way.
  task automatic do_burst(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] t, input int ready_pct, input int stall_at);
    int guard, beats, stall;
    logic rdy;
    logic [63:0] h_addr;
    logic [15:0] h_ctl;
    obs_addr.delete(); obs_strb.delete(); obs_err.delete();
    guard = 0;
    while (!req_ready && guard < 100) begin @(negedge aclk); guard++; end
    chk("req_ready before accept", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_address = a; req_burst_length = l; req_burst_size = s; req_burst_type = t;
    @(negedge aclk);
    req_valid = 1'b0;
    chk("first beat latency", 64'(beat_valid), 64'd1);
    chk("req_ready low in burst", 64'(req_ready), 64'd0);
    beats = 0; stall = 0; guard = 0;
    while (beats <= int'(l) && guard < 4000) begin
      guard++;
      if (!beat_valid) begin
        chk("beat_valid during burst", 64'(beat_valid), 64'd1);
        break;
      end
      if (stall_at == beats && stall < 5) begin rdy = 1'b0; stall++; end
      else rdy = ($urandom_range(0, 99) < ready_pct);
      beat_ready = rdy;
      h_addr = beat_address;
      h_ctl = {beat_strobe, beat_index, beat_last, req_error, beat_valid, req_ready};
      if (rdy) begin
        obs_addr.push_back(beat_address);
        obs_strb.push_back(beat_strobe);
        obs_err.push_back(req_error);
        chk("beat_index", 64'(beat_index), 64'(beats));
        chk("beat_last", 64'(beat_last), 64'(beats == int'(l)));
        // A request offered while the last beat retires must not be taken.
        if (beats == int'(l)) req_valid = 1'b1;
        beats++;
      end
      @(negedge aclk);
      req_valid = 1'b0;
      if (!rdy) begin
        chk("stall address stable", beat_address, h_addr);
        chk("stall control stable",
            64'({beat_strobe, beat_index, beat_last, req_error, beat_valid, req_ready}), 64'(h_ctl));
      end
    end
    beat_ready = 1'b0;
    chk("burst completed in budget", 64'(beats), 64'(int'(l) + 1));
    chk("no beat after last", 64'(beat_valid), 64'd0);
    chk("req_ready after last", 64'(req_ready), 64'd1);
  endtask

  task automatic compare_beats(input string tag);
    chk({tag, " beat count"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      chk($sformatf("%s addr[%0d]", tag, i), obs_addr[i], exp_addr[i]);
      chk($sformatf("%s strobe[%0d]", tag, i), 64'(obs_strb[i]), 64'(exp_strb[i]));
      chk($sformatf("%s req_error[%0d]", tag, i), 64'(obs_err[i]), 64'(exp_err));
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra;
    logic [7:0]  rl;
    logic [2:0]  rs;
    logic [1:0]  rt;

    tbl[0] = mk(64'h1002, 8'd3, 3'd2, 2'b01, 1'b0, 64'h1002, 64'h1004, 64'h1008, 64'h100C, 4'hC, 4'hF, 4'hF, 4'hF);
    tbl[1] = mk(64'h1038, 8'd3, 3'd2, 2'b10, 1'b0, 64'h1038, 64'h103C, 64'h1030, 64'h1034, 4'hF, 4'hF, 4'hF, 4'hF);
    tbl[2] = mk(64'h0020, 8'd2, 3'd1, 2'b00, 1'b0, 64'h0020, 64'h0020, 64'h0020, 64'h0, 4'h3, 4'h3, 4'h3, 4'h0);
    tbl[3] = mk(64'h1000, 8'd2, 3'd2, 2'b10, 1'b1, 64'h1000, 64'h1004, 64'h1008, 64'h0, 4'hF, 4'hF, 4'hF, 4'h0);
    tbl[4] = mk(64'h0100, 8'd1, 3'd3, 2'b01, 1'b1, 64'h0100, 64'h0104, 64'h0, 64'h0, 4'hF, 4'hF, 4'h0, 4'h0);
    tbl[5] = mk(64'h0006, 8'd1, 3'd1, 2'b11, 1'b1, 64'h0006, 64'h0008, 64'h0, 64'h0, 4'hC, 4'h3, 4'h0, 4'h0);
    tbl[6] = mk(64'h1036, 8'd3, 3'd2, 2'b10, 1'b1, 64'h1034, 64'h1038, 64'h103C, 64'h1030, 4'hF, 4'hF, 4'hF, 4'hF);
    tbl[7] = mk(64'h0FF8, 8'd3, 3'd2, 2'b01, PG_ERR, 64'h0FF8, 64'h0FFC, 64'h1000, 64'h1004, 4'hF, 4'hF, 4'hF, 4'hF);
    tbl[8] = mk(64'hFFFF_FFFF_FFFF_FFFC, 8'd1, 3'd2, 2'b01, PG_ERR, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, 64'h0,
                4'hF, 4'hF, 4'h0, 4'h0);
    tbl[9] = mk(64'h0005, 8'd1, 3'd0, 2'b10, 1'b0, 64'h0005, 64'h0004, 64'h0, 64'h0, 4'h2, 4'h1, 4'h0, 4'h0);

    areset = 1'b1; req_valid = 1'b0; beat_ready = 1'b0;
    req_address = 64'h0; req_burst_length = 8'd0; req_burst_size = 3'd0; req_burst_type = 2'b00;
    #1;
    chk("reset req_ready", 64'(req_ready), 64'd1);
    chk("reset beat_valid", 64'(beat_valid), 64'd0);
    chk("reset beat_address", beat_address, 64'h0);
    chk("reset outputs", 64'({beat_strobe, beat_index, beat_last, req_error}), 64'h0);
    @(negedge aclk); @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);

    // Directed table; the FIXED entry also holds beat_ready low for 5 cycles mid-burst.
    for (int i = 0; i < 10; i++) begin
      do_burst(tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].btype, 100, (i == 2) ? 1 : -1);
      exp_addr.delete(); exp_strb.delete();
      exp_err = tbl[i].err;
      for (int j = 0; j <= int'(tbl[i].len); j++) begin
        exp_addr.push_back(tbl[i].a[j]);
        exp_strb.push_back(tbl[i].st[j]);
      end
      compare_beats($sformatf("vec%0d", i));
    end

    // Reset in the middle of an 8-beat burst.
    req_valid = 1'b1; req_address = 64'h400; req_burst_length = 8'd7;
    req_burst_size = 3'd2; req_burst_type = 2'b01;
    @(negedge aclk);
    req_valid = 1'b0; beat_ready = 1'b1;
    @(negedge aclk); @(negedge aclk);
    chk("mid-burst index before reset", 64'(beat_index), 64'd2);
    areset = 1'b1;
    #1;
    chk("reset mid-burst beat_valid", 64'(beat_valid), 64'd0);
    chk("reset mid-burst req_ready", 64'(req_ready), 64'd1);
    chk("reset mid-burst outputs", 64'({beat_strobe, beat_index, beat_last, req_error}), 64'h0);
    beat_ready = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    chk("no beats after reset", 64'(beat_valid), 64'd0);
    chk("req_ready after reset release", 64'(req_ready), 64'd1);
    do_burst(64'h2000, 8'd3, 3'd2, 2'b01, 100, -1);
    model(64'h2000, 8'd3, 3'd2, 2'b01);
    compare_beats("post-reset");

    // Randomised requests against the reference model.
    for (int k = 0; k < 40; k++) begin
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) ra = ra & 64'h3FFF;
      rl = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      rs = 3'($urandom_range(0, 3));
      rt = 2'($urandom_range(0, 3));
      if (rt == 2'b10 && $urandom_range(0, 1) == 1) rl = 8'((2 << $urandom_range(0, 3)) - 1);
      do_burst(ra, rl, rs, rt, 60, -1);
      model(ra, rl, rs, rt);
      compare_beats($sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
